ysyx_220053_axi_master: RTL and testbench

Memory-side sequencer behind the cache arbiter. It takes the single granted request (cache-line or uncached device access) and runs it as AXI4 read or write bursts with 64-bit beats. It assembles or splits the 128-bit line and returns one completion pulse with an error flag. It is the sole owner of the external AXI4 master port.

---
 rtl/ysyx_220053_mem_pkg.sv | 20 ++
 rtl/ysyx_220053_axi_master.sv | 252 +++++++++++++++++++++++++
 tb/tb_ysyx_220053_axi_master.sv | 382 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_220053_mem_pkg.sv
// Shared definitions for the memory-side AXI4 master: sequencer states and
// the fixed AXI encodings it drives.
package ysyx_220053_mem_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_AR,
      S_R,
      S_AW,
      S_W,
      S_B,
      S_DONE
   } state_e;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [2:0] AXI_SIZE_8B    = 3'b011;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
   localparam int         LINE_BEATS     = 2;

endpackage

// File: rtl/ysyx_220053_axi_master.sv
// AXI4 master sequencer: runs one granted cache-line or device request as
// AR/R or AW/W/B bursts of 64-bit beats and returns a single completion pulse.
module ysyx_220053_axi_master
   import ysyx_220053_mem_pkg::*;
#(
   parameter int AXI_ADDR_W = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [63:0]           rw_addr_i,
   input  logic                  rw_req_i,
   input  logic                  rw_valid_i,
   input  logic [127:0]          rw_w_data_i,
   input  logic [7:0]            rw_size_i,
   input  logic                  rw_dev_i,
   output logic [127:0]          rw_data_read_o,
   output logic                  rw_ready_o,
   output logic                  rw_err_o,
   output logic                  ar_valid_o,
   output logic [AXI_ADDR_W-1:0] ar_addr_o,
   output logic [7:0]            ar_len_o,
   output logic [2:0]            ar_size_o,
   output logic [1:0]            ar_burst_o,
   input  logic                  ar_ready_i,
   input  logic                  r_valid_i,
   input  logic [63:0]           r_data_i,
   input  logic [1:0]            r_resp_i,
   input  logic                  r_last_i,
   output logic                  r_ready_o,
   output logic                  aw_valid_o,
   output logic [AXI_ADDR_W-1:0] aw_addr_o,
   output logic [7:0]            aw_len_o,
   output logic [2:0]            aw_size_o,
   output logic [1:0]            aw_burst_o,
   input  logic                  aw_ready_i,
   output logic                  w_valid_o,
   output logic [63:0]           w_data_o,
   output logic [7:0]            w_strb_o,
   output logic                  w_last_o,
   input  logic                  w_ready_i,
   input  logic                  b_valid_i,
   input  logic [1:0]            b_resp_i,
   output logic                  b_ready_o
);

   state_e                state_q, state_d;
   logic                  beat_q, beat_d;
   logic                  dev_q, dev_d;
   logic [7:0]            strb_q, strb_d;
   logic [127:0]          line_q, line_d;
   logic                  err_q, err_d;

   logic                  ar_valid_q, ar_valid_d;
   logic [AXI_ADDR_W-1:0] ar_addr_q, ar_addr_d;
   logic [7:0]            ar_len_q, ar_len_d;
   logic [2:0]            ar_size_q, ar_size_d;
   logic [1:0]            ar_burst_q, ar_burst_d;
   logic                  r_ready_q, r_ready_d;
   logic                  aw_valid_q, aw_valid_d;
   logic [AXI_ADDR_W-1:0] aw_addr_q, aw_addr_d;
   logic [7:0]            aw_len_q, aw_len_d;
   logic [2:0]            aw_size_q, aw_size_d;
   logic [1:0]            aw_burst_q, aw_burst_d;
   logic                  w_valid_q, w_valid_d;
   logic [63:0]           w_data_q, w_data_d;
   logic [7:0]            w_strb_q, w_strb_d;
   logic                  w_last_q, w_last_d;
   logic                  b_ready_q, b_ready_d;
   logic                  rw_ready_q, rw_ready_d;
   logic                  rw_err_q, rw_err_d;

   logic [AXI_ADDR_W-1:0] req_addr;
   logic [7:0]            req_len;
   logic                  final_beat;
   logic                  unused_addr;

   assign unused_addr = ^rw_addr_i;

   always_comb begin
      state_d    = state_q;
      beat_d     = beat_q;
      dev_d      = dev_q;
      strb_d     = strb_q;
      line_d     = line_q;
      err_d      = err_q;
      ar_addr_d  = ar_addr_q;
      ar_len_d   = ar_len_q;
      ar_size_d  = ar_size_q;
      ar_burst_d = ar_burst_q;
      aw_addr_d  = aw_addr_q;
      aw_len_d   = aw_len_q;
      aw_size_d  = aw_size_q;
      aw_burst_d = aw_burst_q;
      w_data_d   = w_data_q;
      w_strb_d   = w_strb_q;
      w_last_d   = w_last_q;

      // Lines are always fetched from the 16B boundary; device accesses go out as-is.
      req_addr   = rw_dev_i ? rw_addr_i[AXI_ADDR_W-1:0]
                            : {rw_addr_i[AXI_ADDR_W-1:4], 4'h0};
      req_len    = rw_dev_i ? 8'd0 : 8'(LINE_BEATS - 1);
      final_beat = dev_q | (beat_q == 1'(LINE_BEATS - 1));

      unique case (state_q)
         S_IDLE: begin
            if (rw_valid_i) begin
               dev_d  = rw_dev_i;
               strb_d = rw_size_i;
               beat_d = 1'b0;
               err_d  = 1'b0;
               if (rw_req_i) begin
                  line_d     = rw_w_data_i;
                  aw_addr_d  = req_addr;
                  aw_len_d   = req_len;
                  aw_size_d  = AXI_SIZE_8B;
                  aw_burst_d = AXI_BURST_INCR;
                  state_d    = S_AW;
               end else begin
                  // Cleared so a device read returns zeros in the upper half.
                  line_d     = '0;
                  ar_addr_d  = req_addr;
                  ar_len_d   = req_len;
                  ar_size_d  = AXI_SIZE_8B;
                  ar_burst_d = AXI_BURST_INCR;
                  state_d    = S_AR;
               end
            end
         end
         S_AR: begin
            if (ar_ready_i) state_d = S_R;
         end
         S_R: begin
            if (r_valid_i && r_ready_q) begin
               if (beat_q) line_d[127:64] = r_data_i;
               else        line_d[63:0]   = r_data_i;
               if ((r_resp_i != AXI_RESP_OKAY) || (r_last_i != final_beat)) err_d = 1'b1;
               beat_d = beat_q + 1'b1;
               if (r_last_i || final_beat) state_d = S_DONE;
            end
         end
         S_AW: begin
            if (aw_ready_i) begin
               beat_d  = 1'b0;
               state_d = S_W;
            end
         end
         S_W: begin
            if (w_ready_i) begin
               if (final_beat) state_d = S_B;
               else            beat_d  = beat_q + 1'b1;
            end
         end
         S_B: begin
            if (b_valid_i) begin
               if (b_resp_i != AXI_RESP_OKAY) err_d = 1'b1;
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Every output is a flop loaded from the next state, so it lines up with the state register.
      ar_valid_d = (state_d == S_AR);
      r_ready_d  = (state_d == S_R);
      aw_valid_d = (state_d == S_AW);
      w_valid_d  = (state_d == S_W);
      b_ready_d  = (state_d == S_B);
      rw_ready_d = (state_d == S_DONE);
      rw_err_d   = (state_d == S_DONE) && err_d;
      if (state_d == S_W) begin
         w_data_d = beat_d ? line_d[127:64] : line_d[63:0];
         w_last_d = dev_d | beat_d;
         w_strb_d = dev_d ? strb_d : 8'hFF;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         beat_q     <= 1'b0;
         dev_q      <= 1'b0;
         strb_q     <= '0;
         line_q     <= '0;
         err_q      <= 1'b0;
         ar_valid_q <= 1'b0;
         ar_addr_q  <= '0;
         ar_len_q   <= '0;
         ar_size_q  <= '0;
         ar_burst_q <= '0;
         r_ready_q  <= 1'b0;
         aw_valid_q <= 1'b0;
         aw_addr_q  <= '0;
         aw_len_q   <= '0;
         aw_size_q  <= '0;
         aw_burst_q <= '0;
         w_valid_q  <= 1'b0;
         w_data_q   <= '0;
         w_strb_q   <= '0;
         w_last_q   <= 1'b0;
         b_ready_q  <= 1'b0;
         rw_ready_q <= 1'b0;
         rw_err_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         beat_q     <= beat_d;
         dev_q      <= dev_d;
         strb_q     <= strb_d;
         line_q     <= line_d;
         err_q      <= err_d;
         ar_valid_q <= ar_valid_d;
         ar_addr_q  <= ar_addr_d;
         ar_len_q   <= ar_len_d;
         ar_size_q  <= ar_size_d;
         ar_burst_q <= ar_burst_d;
         r_ready_q  <= r_ready_d;
         aw_valid_q <= aw_valid_d;
         aw_addr_q  <= aw_addr_d;
         aw_len_q   <= aw_len_d;
         aw_size_q  <= aw_size_d;
         aw_burst_q <= aw_burst_d;
         w_valid_q  <= w_valid_d;
         w_data_q   <= w_data_d;
         w_strb_q   <= w_strb_d;
         w_last_q   <= w_last_d;
         b_ready_q  <= b_ready_d;
         rw_ready_q <= rw_ready_d;
         rw_err_q   <= rw_err_d;
      end
   end

   assign rw_data_read_o = line_q;
   assign rw_ready_o     = rw_ready_q;
   assign rw_err_o       = rw_err_q;
   assign ar_valid_o     = ar_valid_q;
   assign ar_addr_o      = ar_addr_q;
   assign ar_len_o       = ar_len_q;
   assign ar_size_o      = ar_size_q;
   assign ar_burst_o     = ar_burst_q;
   assign r_ready_o      = r_ready_q;
   assign aw_valid_o     = aw_valid_q;
   assign aw_addr_o      = aw_addr_q;
   assign aw_len_o       = aw_len_q;
   assign aw_size_o      = aw_size_q;
   assign aw_burst_o     = aw_burst_q;
   assign w_valid_o      = w_valid_q;
   assign w_data_o       = w_data_q;
   assign w_strb_o       = w_strb_q;
   assign w_last_o       = w_last_q;
   assign b_ready_o      = b_ready_q;

endmodule

// File: tb/tb_ysyx_220053_axi_master.sv
// Bench for ysyx_220053_axi_master: scripted AXI slave responses per scenario,
// completions checked against a queue of expected results.
module tb_ysyx_220053_axi_master;

   logic         clk = 1'b0;
   logic         rst;
   logic [63:0]  rw_addr;
   logic         rw_req, rw_valid, rw_dev;
   logic [127:0] rw_w_data;
   logic [7:0]   rw_size;
   logic [127:0] rw_data_read_o;
   logic         rw_ready_o, rw_err_o;
   logic         ar_valid_o, ar_ready;
   logic [31:0]  ar_addr_o, aw_addr_o;
   logic [7:0]   ar_len_o, aw_len_o;
   logic [2:0]   ar_size_o, aw_size_o;
   logic [1:0]   ar_burst_o, aw_burst_o;
   logic         r_valid, r_last, r_ready_o;
   logic [63:0]  r_data;
   logic [1:0]   r_resp, b_resp;
   logic         aw_valid_o, aw_ready;
   logic         w_valid_o, w_last_o, w_ready;
   logic [63:0]  w_data_o;
   logic [7:0]   w_strb_o;
   logic         b_valid, b_ready_o;

   typedef struct {
      logic [127:0] data;
      logic [127:0] mask;
      logic         err;
   } exp_t;

   exp_t exp_q[$];
   int   vectors = 0;
   int   miscompares = 0;

   localparam logic [127:0] ALL  = {128{1'b1}};
   localparam logic [127:0] LOW  = {64'h0, {64{1'b1}}};
   localparam logic [127:0] NONE = 128'h0;

   always #5 clk = ~clk;

   ysyx_220053_axi_master #(.AXI_ADDR_W(32)) dut (
      .clk(clk), .rst(rst),
      .rw_addr_i(rw_addr), .rw_req_i(rw_req), .rw_valid_i(rw_valid),
      .rw_w_data_i(rw_w_data), .rw_size_i(rw_size), .rw_dev_i(rw_dev),
      .rw_data_read_o(rw_data_read_o), .rw_ready_o(rw_ready_o), .rw_err_o(rw_err_o),
      .ar_valid_o(ar_valid_o), .ar_addr_o(ar_addr_o), .ar_len_o(ar_len_o),
      .ar_size_o(ar_size_o), .ar_burst_o(ar_burst_o), .ar_ready_i(ar_ready),
      .r_valid_i(r_valid), .r_data_i(r_data), .r_resp_i(r_resp), .r_last_i(r_last),
      .r_ready_o(r_ready_o),
      .aw_valid_o(aw_valid_o), .aw_addr_o(aw_addr_o), .aw_len_o(aw_len_o),
      .aw_size_o(aw_size_o), .aw_burst_o(aw_burst_o), .aw_ready_i(aw_ready),
      .w_valid_o(w_valid_o), .w_data_o(w_data_o), .w_strb_o(w_strb_o),
      .w_last_o(w_last_o), .w_ready_i(w_ready),
      .b_valid_i(b_valid), .b_resp_i(b_resp), .b_ready_o(b_ready_o)
   );

   // Completion scoreboard: every rw_ready_o pulse must match the oldest expectation.
   always @(negedge clk) begin
      if (rw_ready_o) begin
         exp_t e;
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_done rw_ready_o=1 with no request outstanding");
         end else begin
            e = exp_q.pop_front();
            vectors++;
            if ((rw_data_read_o & e.mask) !== (e.data & e.mask)) begin
               miscompares++;
               $display("FAIL done_data got %h want %h (mask %h)", rw_data_read_o, e.data, e.mask);
            end
            vectors++;
            if (rw_err_o !== e.err) begin
               miscompares++;
               $display("FAIL done_err got %b want %b", rw_err_o, e.err);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic req(input logic [63:0] a, input logic wr, input logic dev,
                      input logic [127:0] wd, input logic [7:0] sz);
      rw_addr = a; rw_req = wr; rw_dev = dev; rw_w_data = wd; rw_size = sz; rw_valid = 1'b1;
   endtask

   task automatic push(input logic [127:0] d, input logic [127:0] m, input logic e);
      exp_t x;
      x.data = d; x.mask = m; x.err = e;
      exp_q.push_back(x);
   endtask

   task automatic test_reset();
      logic [6:0]   ctl;
      logic [163:0] pay;
      rst = 1'b1;
      repeat (3) tick();
      ctl = {ar_valid_o, r_ready_o, aw_valid_o, w_valid_o, b_ready_o, rw_ready_o, rw_err_o};
      vectors++;
      if (ctl !== 7'b0) begin
         miscompares++; $display("FAIL reset_ctl got %b want 0", ctl);
      end
      pay = {ar_addr_o, ar_len_o, ar_size_o, ar_burst_o, aw_addr_o, aw_len_o, aw_size_o,
             aw_burst_o, w_data_o, w_strb_o, w_last_o};
      vectors++;
      if (pay !== '0) begin
         miscompares++; $display("FAIL reset_payload got %h want 0", pay);
      end
      vectors++;
      if (rw_data_read_o !== 128'h0) begin
         miscompares++; $display("FAIL reset_rdata got %h want 0", rw_data_read_o);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_line_read();
      logic [45:0] ar;
      req(64'h8000_0010, 1'b0, 1'b0, '0, 8'h00);
      push({64'h0000_0000_BBBB_1111, 64'h0000_0000_AAAA_0000}, ALL, 1'b0);
      tick(); // c1
      ar = {ar_valid_o, ar_addr_o, ar_len_o, ar_size_o, ar_burst_o};
      vectors++;
      if (ar !== {1'b1, 32'h8000_0010, 8'd1, 3'b011, 2'b01}) begin
         miscompares++; $display("FAIL line_read_ar got %h want %h", ar, {1'b1, 32'h8000_0010, 8'd1, 3'b011, 2'b01});
      end
      ar_ready = 1'b1;
      tick(); // c2
      ar_ready = 1'b0;
      vectors++;
      if ({ar_valid_o, r_ready_o} !== 2'b01) begin
         miscompares++; $display("FAIL line_read_rready got %b want 01", {ar_valid_o, r_ready_o});
      end
      r_valid = 1'b1; r_data = 64'hAAAA_0000; r_resp = 2'b00; r_last = 1'b0;
      tick(); // c3
      r_data = 64'hBBBB_1111; r_last = 1'b1;
      tick(); // c4
      r_valid = 1'b0; r_last = 1'b0;
      vectors++;
      if (rw_ready_o !== 1'b1) begin
         miscompares++; $display("FAIL line_read_latency rw_ready_o got %b want 1 at c4", rw_ready_o);
      end
      rw_valid = 1'b0;
      tick(); // c5
      vectors++;
      if ({rw_ready_o, r_ready_o} !== 2'b00) begin
         miscompares++; $display("FAIL line_read_pulse got %b want 00", {rw_ready_o, r_ready_o});
      end
   endtask

   task automatic test_line_write_stall();
      logic [127:0] wd;
      logic [45:0]  aw;
      logic [74:0]  w;
      wd = 128'h1122_3344_5566_7788_9900_AABB_CCDD_EEFF;
      req(64'h8000_0020, 1'b1, 1'b0, wd, 8'h00);
      push(NONE, NONE, 1'b0);
      tick(); // c1
      aw = {aw_valid_o, aw_addr_o, aw_len_o, aw_size_o, aw_burst_o};
      vectors++;
      if (aw !== {1'b1, 32'h8000_0020, 8'd1, 3'b011, 2'b01} || w_valid_o !== 1'b0) begin
         miscompares++; $display("FAIL line_write_aw got %h w_valid %b", aw, w_valid_o);
      end
      aw_ready = 1'b1;
      tick(); // c2
      aw_ready = 1'b0;
      w = {aw_valid_o, w_valid_o, w_data_o, w_strb_o, w_last_o};
      vectors++;
      if (w !== {1'b0, 1'b1, wd[63:0], 8'hFF, 1'b0}) begin
         miscompares++; $display("FAIL line_write_w0 got %h want %h", w, {1'b0, 1'b1, wd[63:0], 8'hFF, 1'b0});
      end
      w_ready = 1'b1;
      tick(); // c3
      w_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         w = {b_ready_o, w_valid_o, w_data_o, w_strb_o, w_last_o};
         vectors++;
         if (w !== {1'b0, 1'b1, wd[127:64], 8'hFF, 1'b1}) begin
            miscompares++; $display("FAIL line_write_w1_stall%0d got %h want %h", i, w, {1'b0, 1'b1, wd[127:64], 8'hFF, 1'b1});
         end
         tick();
      end
      w_ready = 1'b1;
      tick();
      w_ready = 1'b0;
      vectors++;
      if ({w_valid_o, b_ready_o, rw_ready_o} !== 3'b010) begin
         miscompares++; $display("FAIL line_write_b got %b want 010", {w_valid_o, b_ready_o, rw_ready_o});
      end
      b_valid = 1'b1; b_resp = 2'b00;
      tick();
      b_valid = 1'b0;
      vectors++;
      if ({rw_ready_o, b_ready_o} !== 2'b10) begin
         miscompares++; $display("FAIL line_write_done got %b want 10", {rw_ready_o, b_ready_o});
      end
      rw_valid = 1'b0;
      tick();
   endtask

   task automatic test_dev_write();
      logic [45:0] aw;
      logic [73:0] w;
      req(64'h0000_0000_A000_03F8, 1'b1, 1'b1, {64'hFFFF_FFFF_FFFF_FFFF, 64'hDEAD_BEEF_CAFE_F00D}, 8'h0F);
      push(NONE, NONE, 1'b0);
      tick(); // c1
      aw = {aw_valid_o, aw_addr_o, aw_len_o, aw_size_o, aw_burst_o};
      vectors++;
      if (aw !== {1'b1, 32'hA000_03F8, 8'd0, 3'b011, 2'b01}) begin
         miscompares++; $display("FAIL dev_write_aw got %h want %h", aw, {1'b1, 32'hA000_03F8, 8'd0, 3'b011, 2'b01});
      end
      aw_ready = 1'b1;
      tick(); // c2
      aw_ready = 1'b0;
      w = {w_valid_o, w_data_o, w_strb_o, w_last_o};
      vectors++;
      if (w !== {1'b1, 64'hDEAD_BEEF_CAFE_F00D, 8'h0F, 1'b1}) begin
         miscompares++; $display("FAIL dev_write_w got %h want %h", w, {1'b1, 64'hDEAD_BEEF_CAFE_F00D, 8'h0F, 1'b1});
      end
      w_ready = 1'b1;
      tick(); // c3
      w_ready = 1'b0;
      b_valid = 1'b1; b_resp = 2'b00;
      tick(); // c4
      b_valid = 1'b0;
      vectors++;
      if (rw_ready_o !== 1'b1) begin
         miscompares++; $display("FAIL dev_write_latency rw_ready_o got %b want 1 at c4", rw_ready_o);
      end
      rw_valid = 1'b0;
      tick();
   endtask

   task automatic test_dev_read_err();
      logic [45:0] ar;
      req(64'h0000_0000_A000_0104, 1'b0, 1'b1, '0, 8'h00);
      push({64'h0, 64'h0123_4567_89AB_CDEF}, ALL, 1'b1);
      tick(); // c1
      ar = {ar_valid_o, ar_addr_o, ar_len_o, ar_size_o, ar_burst_o};
      vectors++;
      if (ar !== {1'b1, 32'hA000_0104, 8'd0, 3'b011, 2'b01}) begin
         miscompares++; $display("FAIL dev_read_ar got %h want %h", ar, {1'b1, 32'hA000_0104, 8'd0, 3'b011, 2'b01});
      end
      // A stray beat while still in AR must not be acknowledged or captured.
      r_valid = 1'b1; r_data = 64'h5A5A_5A5A_5A5A_5A5A; r_resp = 2'b00; r_last = 1'b1;
      vectors++;
      if (r_ready_o !== 1'b0) begin
         miscompares++; $display("FAIL dev_read_stray_r r_ready_o got %b want 0", r_ready_o);
      end
      ar_ready = 1'b1;
      tick(); // c2
      ar_ready = 1'b0;
      r_data = 64'h0123_4567_89AB_CDEF; r_resp = 2'b10; r_last = 1'b1;
      tick(); // c3
      r_valid = 1'b0; r_last = 1'b0; r_resp = 2'b00;
      vectors++;
      if (rw_ready_o !== 1'b1) begin
         miscompares++; $display("FAIL dev_read_latency rw_ready_o got %b want 1 at c3", rw_ready_o);
      end
      rw_valid = 1'b0;
      tick();
   endtask

   task automatic test_early_last();
      req(64'h8000_0048, 1'b0, 1'b0, '0, 8'h00);
      push({64'h0, 64'h5555_6666_7777_8888}, LOW, 1'b1);
      tick(); // c1, ready held low for one cycle
      tick(); // c2
      vectors++;
      if ({ar_valid_o, ar_addr_o, r_ready_o} !== {1'b1, 32'h8000_0040, 1'b0}) begin
         miscompares++; $display("FAIL early_last_ar_stall got %b/%h/%b want 1/80000040/0", ar_valid_o, ar_addr_o, r_ready_o);
      end
      ar_ready = 1'b1;
      tick();
      ar_ready = 1'b0;
      r_valid = 1'b1; r_data = 64'h5555_6666_7777_8888; r_resp = 2'b00; r_last = 1'b1;
      tick();
      r_valid = 1'b0; r_last = 1'b0;
      vectors++;
      if ({rw_ready_o, r_ready_o} !== 2'b10) begin
         miscompares++; $display("FAIL early_last_done got %b want 10", {rw_ready_o, r_ready_o});
      end
      rw_valid = 1'b0;
      tick();
   endtask

   task automatic test_missing_last();
      req(64'h8000_0080, 1'b0, 1'b0, '0, 8'h00);
      push({64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, ALL, 1'b1);
      tick();
      ar_ready = 1'b1;
      tick();
      ar_ready = 1'b0;
      r_valid = 1'b1; r_data = 64'h1111_1111_1111_1111; r_resp = 2'b00; r_last = 1'b0;
      tick();
      r_data = 64'h2222_2222_2222_2222;
      tick();
      r_valid = 1'b0;
      vectors++;
      if (rw_ready_o !== 1'b1) begin
         miscompares++; $display("FAIL missing_last_done rw_ready_o got %b want 1", rw_ready_o);
      end
      rw_valid = 1'b0;
      tick();
   endtask

   task automatic test_rst_mid();
      logic [79:0] o;
      req(64'h8000_00C0, 1'b1, 1'b0, 128'hCAFE_0000_0000_0001_BEEF_0000_0000_0002, 8'h00);
      tick();
      aw_ready = 1'b1;
      tick();
      aw_ready = 1'b0;
      w_ready = 1'b1;
      tick(); // now in W on beat 1
      w_ready = 1'b0;
      vectors++;
      if ({w_valid_o, w_last_o} !== 2'b11) begin
         miscompares++; $display("FAIL rst_mid_w1 got %b want 11", {w_valid_o, w_last_o});
      end
      rst = 1'b1; rw_valid = 1'b0;
      tick();
      o = {w_valid_o, aw_valid_o, b_ready_o, rw_ready_o, rw_err_o, w_last_o, w_data_o, w_strb_o, 2'b00};
      vectors++;
      if (o !== '0 || rw_data_read_o !== 128'h0) begin
         miscompares++; $display("FAIL rst_mid_outputs got %h rdata %h want 0", o, rw_data_read_o);
      end
      rst = 1'b0;
      tick();
      req(64'h0000_0000_A000_0010, 1'b0, 1'b1, '0, 8'h00);
      push({64'h0, 64'h0F0F_0F0F_0F0F_0F0F}, ALL, 1'b0);
      tick();
      vectors++;
      if ({ar_valid_o, ar_addr_o} !== {1'b1, 32'hA000_0010}) begin
         miscompares++; $display("FAIL rst_mid_next_ar got %b/%h want 1/a0000010", ar_valid_o, ar_addr_o);
      end
      ar_ready = 1'b1;
      tick();
      ar_ready = 1'b0;
      r_valid = 1'b1; r_data = 64'h0F0F_0F0F_0F0F_0F0F; r_resp = 2'b00; r_last = 1'b1;
      tick();
      r_valid = 1'b0; r_last = 1'b0;
      vectors++;
      if (rw_ready_o !== 1'b1) begin
         miscompares++; $display("FAIL rst_mid_next_done rw_ready_o got %b want 1", rw_ready_o);
      end
      rw_valid = 1'b0;
      tick();
   endtask

   initial begin
      rst = 1'b1;
      rw_addr = '0; rw_req = 1'b0; rw_valid = 1'b0; rw_dev = 1'b0; rw_w_data = '0; rw_size = '0;
      ar_ready = 1'b0; aw_ready = 1'b0; w_ready = 1'b0;
      r_valid = 1'b0; r_data = '0; r_resp = 2'b00; r_last = 1'b0;
      b_valid = 1'b0; b_resp = 2'b00;

      test_reset();
      test_line_read();
      test_line_write_stall();
      test_dev_write();
      test_dev_read_err();
      test_early_last();
      test_missing_last();
      test_rst_mid();

      repeat (3) tick();
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++; $display("FAIL outstanding_completions got %0d want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
